// File: rtl/dummy_op_handler_pkg.sv
// Shared definitions for the filler op handlers: position widths,
// handler state encoding and the busy-counter width helper.
package dummy_op_handler_pkg;

  localparam int DEF_POS_X_BITS   = 16;
  localparam int DEF_POS_Y_BITS   = 16;
  localparam int DEF_BUSY_CYCLES  = 4;

  typedef enum logic [1:0] {
    HDL_IDLE = 2'd0,
    HDL_BUSY = 2'd1,
    HDL_DONE = 2'd2
  } hdl_state_e;

  // Counter must hold BUSY_CYCLES-1 as its load value.
  function automatic int busy_cnt_width(input int busy_cycles);
    return (busy_cycles < 2) ? 1 : $clog2(busy_cycles + 1);
  endfunction

endpackage

// File: rtl/dummy_op_handler_busy_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// Latency 1 cycle; no backpressure, callers qualify load/dec with their enable.
module dummy_op_handler_busy_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dummy_op_handler.sv
// Filler op handler: latches the current position on trigger, stays busy
// BUSY_CYCLES enabled cycles, pulses done; motor outputs are tied idle.
module dummy_op_handler
  import dummy_op_handler_pkg::*;
#(
  parameter int POS_X_BITS  = DEF_POS_X_BITS,
  parameter int POS_Y_BITS  = DEF_POS_Y_BITS,
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         hdl_trigger,
  output logic                         hdl_done,
  output logic                         hdl_rdy,
  output logic signed [POS_X_BITS-1:0] mot_pulse_num_x,
  output logic signed [POS_Y_BITS-1:0] mot_pulse_num_y,
  output logic                         mot_trigger,
  input  logic                         mot_done,
  input  logic                         mot_rdy,
  input  logic signed [POS_X_BITS-1:0] pos_cur_x,
  input  logic signed [POS_Y_BITS-1:0] pos_cur_y,
  output logic signed [POS_X_BITS-1:0] pos_new_x,
  output logic signed [POS_Y_BITS-1:0] pos_new_y
);

  localparam int CNT_W = busy_cnt_width(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

  hdl_state_e state_q, state_d;
  logic       done_q, done_d;
  logic signed [POS_X_BITS-1:0] pos_new_x_q, pos_new_x_d;
  logic signed [POS_Y_BITS-1:0] pos_new_y_q, pos_new_y_d;

  logic timer_load;
  logic timer_dec;
  logic timer_zero;
  logic unused_mot;

  dummy_op_handler_busy_timer #(
    .WIDTH (CNT_W)
  ) u_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (CNT_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign timer_load = clk_en && (state_q == HDL_IDLE) && hdl_trigger;
  assign timer_dec  = clk_en && (state_q == HDL_BUSY);

  always_comb begin
    state_d     = state_q;
    pos_new_x_d = pos_new_x_q;
    pos_new_y_d = pos_new_y_q;
    if (clk_en) begin
      case (state_q)
        HDL_IDLE: begin
          if (hdl_trigger) begin
            state_d     = HDL_BUSY;
            pos_new_x_d = pos_cur_x;
            pos_new_y_d = pos_cur_y;
          end
        end
        HDL_BUSY: begin
          if (timer_zero) begin
            state_d = HDL_DONE;
          end
        end
        HDL_DONE: state_d = HDL_IDLE;
        default:  state_d = HDL_IDLE;
      endcase
    end
    // Done is a flop that mirrors the DONE state, so it holds with clk_en low.
    done_d = (state_d == HDL_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HDL_IDLE;
      done_q      <= 1'b0;
      pos_new_x_q <= '0;
      pos_new_y_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pos_new_x_q <= pos_new_x_d;
      pos_new_y_q <= pos_new_y_d;
    end
  end

  assign hdl_done  = done_q;
  assign hdl_rdy   = (state_q == HDL_IDLE);
  assign pos_new_x = pos_new_x_q;
  assign pos_new_y = pos_new_y_q;

  // This handler never commands the motors; their status inputs are don't-care.
  assign mot_pulse_num_x = '0;
  assign mot_pulse_num_y = '0;
  assign mot_trigger     = 1'b0;
  assign unused_mot      = &{1'b0, mot_done, mot_rdy};

endmodule

// File: tb/tb_dummy_op_handler.sv
// Directed vector table plus hand-written held-trigger and motor-isolation runs.
module tb_dummy_op_handler;
  import dummy_op_handler_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic               hdl_trigger;
  logic               hdl_done;
  logic               hdl_rdy;
  logic signed [15:0] mot_pulse_num_x;
  logic signed [15:0] mot_pulse_num_y;
  logic               mot_trigger;
  logic               mot_done;
  logic               mot_rdy;
  logic signed [15:0] pos_cur_x;
  logic signed [15:0] pos_cur_y;
  logic signed [15:0] pos_new_x;
  logic signed [15:0] pos_new_y;

  int n_cmp  = 0;
  int n_fail = 0;

  dummy_op_handler #(
    .POS_X_BITS  (16),
    .POS_Y_BITS  (16),
    .BUSY_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .hdl_trigger     (hdl_trigger),
    .hdl_done        (hdl_done),
    .hdl_rdy         (hdl_rdy),
    .mot_pulse_num_x (mot_pulse_num_x),
    .mot_pulse_num_y (mot_pulse_num_y),
    .mot_trigger     (mot_trigger),
    .mot_done        (mot_done),
    .mot_rdy         (mot_rdy),
    .pos_cur_x       (pos_cur_x),
    .pos_cur_y       (pos_cur_y),
    .pos_new_x       (pos_new_x),
    .pos_new_y       (pos_new_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic               rst_n;
    logic               en;
    logic               trig;
    logic               md;
    logic               mr;
    logic signed [15:0] cx;
    logic signed [15:0] cy;
    logic               e_rdy;
    logic               e_done;
    logic signed [15:0] e_x;
    logic signed [15:0] e_y;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input string name, input logic rst_n, input logic en,
                              input logic trig, input logic md, input logic mr,
                              input int cx, input int cy, input logic e_rdy,
                              input logic e_done, input int e_x, input int e_y);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.en = en; v.trig = trig; v.md = md; v.mr = mr;
    v.cx = 16'(cx); v.cy = 16'(cy); v.e_rdy = e_rdy; v.e_done = e_done;
    v.e_x = 16'(e_x); v.e_y = 16'(e_y);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and sample just after it; motor outputs must always be idle.
  task automatic step();
    @(posedge clk);
    #1;
    check("mot_trigger", {31'b0, mot_trigger}, 32'd0);
    check("mot_pulse_x", 32'(mot_pulse_num_x), 32'd0);
    check("mot_pulse_y", 32'(mot_pulse_num_y), 32'd0);
  endtask

  int done_cnt;

  initial begin
    reset = 1'b0; clk_en = 1'b1; hdl_trigger = 1'b0;
    mot_done = 1'b0; mot_rdy = 1'b0; pos_cur_x = '0; pos_cur_y = '0;

    //               name          rst en tr md mr  cx    cy   rdy dn  ex   ey
    vecs[0]  = mk("rst_hold0",     0, 1, 0, 0, 0,   0,    0,  1, 0,   0,   0);
    vecs[1]  = mk("rst_over_trig", 0, 1, 1, 0, 0,   3,    4,  1, 0,   0,   0);
    vecs[2]  = mk("trig_e0",       1, 1, 1, 0, 0,  12,   -7,  0, 0,  12,  -7);
    vecs[3]  = mk("busy_ign_trig", 1, 1, 1, 0, 0,  99,   99,  0, 0,  12,  -7);
    vecs[4]  = mk("busy_cnt2",     1, 1, 0, 0, 0,  99,   99,  0, 0,  12,  -7);
    vecs[5]  = mk("busy_cnt1",     1, 1, 0, 0, 0,  99,   99,  0, 0,  12,  -7);
    vecs[6]  = mk("done_pulse",    1, 1, 0, 0, 0,  99,   99,  0, 1,  12,  -7);
    vecs[7]  = mk("back_idle",     1, 1, 0, 0, 0,  99,   99,  1, 0,  12,  -7);
    vecs[8]  = mk("idle_quiet",    1, 1, 0, 0, 0,  99,   99,  1, 0,  12,  -7);
    vecs[9]  = mk("en0_trig",      1, 0, 1, 0, 0,   5,    6,  1, 0,  12,  -7);
    vecs[10] = mk("gate_e1",       1, 1, 1, 0, 0,  -1,  300,  0, 0,  -1, 300);
    vecs[11] = mk("gate_hold_a",   1, 0, 1, 0, 0,  -1,  300,  0, 0,  -1, 300);
    vecs[12] = mk("gate_e2",       1, 1, 0, 0, 0,  -1,  300,  0, 0,  -1, 300);
    vecs[13] = mk("gate_hold_b",   1, 0, 0, 1, 1,  -1,  300,  0, 0,  -1, 300);
    vecs[14] = mk("gate_e3",       1, 1, 0, 0, 0,  -1,  300,  0, 0,  -1, 300);
    vecs[15] = mk("gate_e4",       1, 1, 0, 0, 0,  -1,  300,  0, 0,  -1, 300);
    vecs[16] = mk("gate_hold_c",   1, 0, 0, 0, 0,  -1,  300,  0, 0,  -1, 300);
    vecs[17] = mk("gate_e5_done",  1, 1, 0, 0, 0,  -1,  300,  0, 1,  -1, 300);
    vecs[18] = mk("gate_done_hold",1, 0, 0, 0, 0,  -1,  300,  0, 1,  -1, 300);
    vecs[19] = mk("gate_idle",     1, 1, 0, 0, 0,  -1,  300,  1, 0,  -1, 300);
    vecs[20] = mk("mid_trig",      1, 1, 1, 0, 0,   7,    8,  0, 0,   7,   8);
    vecs[21] = mk("mid_busy2",     1, 1, 0, 0, 0,   7,    8,  0, 0,   7,   8);
    vecs[22] = mk("mid_reset",     0, 1, 0, 0, 0,   7,    8,  1, 0,   0,   0);
    vecs[23] = mk("mid_after0",    1, 1, 0, 0, 0,   7,    8,  1, 0,   0,   0);
    vecs[24] = mk("mid_after1",    1, 1, 0, 0, 0,   7,    8,  1, 0,   0,   0);
    vecs[25] = mk("dr_trig",       1, 1, 1, 0, 0,   1,    2,  0, 0,   1,   2);
    vecs[26] = mk("dr_busy2",      1, 1, 0, 0, 0,   1,    2,  0, 0,   1,   2);
    vecs[27] = mk("dr_busy3",      1, 1, 0, 0, 0,   1,    2,  0, 0,   1,   2);
    vecs[28] = mk("dr_busy4",      1, 1, 0, 0, 0,   1,    2,  0, 0,   1,   2);
    vecs[29] = mk("dr_done",       1, 1, 0, 0, 0,   1,    2,  0, 1,   1,   2);
    vecs[30] = mk("dr_reset",      0, 1, 0, 0, 0,   1,    2,  1, 0,   0,   0);
    vecs[31] = mk("dr_after",      1, 1, 0, 0, 0,   1,    2,  1, 0,   0,   0);

    for (int i = 0; i < 32; i++) begin
      reset = vecs[i].rst_n; clk_en = vecs[i].en; hdl_trigger = vecs[i].trig;
      mot_done = vecs[i].md; mot_rdy = vecs[i].mr;
      pos_cur_x = vecs[i].cx; pos_cur_y = vecs[i].cy;
      step();
      check({vecs[i].name, ".rdy"},  {31'b0, hdl_rdy},  {31'b0, vecs[i].e_rdy});
      check({vecs[i].name, ".done"}, {31'b0, hdl_done}, {31'b0, vecs[i].e_done});
      check({vecs[i].name, ".x"},    32'(pos_new_x),    32'(vecs[i].e_x));
      check({vecs[i].name, ".y"},    32'(pos_new_y),    32'(vecs[i].e_y));
    end

    // Held trigger: IDLE 1 + BUSY 4 + DONE 1 gives a 6-cycle repeat.
    reset = 1'b1; clk_en = 1'b1; hdl_trigger = 1'b1;
    mot_done = 1'b0; mot_rdy = 1'b0; pos_cur_x = 16'sd20; pos_cur_y = -16'sd20;
    for (int k = 0; k < 20; k++) begin
      step();
      check("held.done", {31'b0, hdl_done}, {31'b0, (k % 6) == 4});
      check("held.rdy",  {31'b0, hdl_rdy},  {31'b0, (k % 6) == 5});
      check("held.x",    32'(pos_new_x),    32'(16'sd20));
    end

    // Motor isolation: random motor status during one op, done timing unchanged.
    reset = 1'b0; hdl_trigger = 1'b0;
    step();
    reset = 1'b1; hdl_trigger = 1'b1; pos_cur_x = -16'sd3; pos_cur_y = 16'sd4;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      mot_done = 1'($urandom_range(0, 1));
      mot_rdy  = 1'($urandom_range(0, 1));
      step();
      hdl_trigger = 1'b0;
      if (hdl_done) done_cnt++;
      check("iso.done", {31'b0, hdl_done}, {31'b0, k == 4});
      check("iso.rdy",  {31'b0, hdl_rdy},  {31'b0, k >= 5});
      check("iso.y",    32'(pos_new_y),    32'(16'sd4));
    end
    check("iso.done_count", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
